matrix_inv_q2_14: RTL and testbench

- Sequential 2x2 matrix inverter in Q2.14 format. It is the inverse-direction companion to the team's combinational 2x2 Q2.14 multiplier: for an input A it produces C = A^-1, so that A*C is approximately I.
- It computes the determinant once, then runs one shared restoring divider over the four adjugate entries in turn.
- Valid/ready handshakes on both sides, so it drops into the same datapath as the multiplier.

---
 rtl/matrix_inv_q2_14.sv | 195 +++++++++++++++++++
 tb/tb_matrix_inv_q2_14.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/matrix_inv_q2_14.sv
// Sequential 2x2 Q2.14 matrix inverter: determinant in one cycle, then one shared
// restoring divider over the four adjugate entries, valid/ready on both sides.
module matrix_inv_q2_14 #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A00,
    input  logic [WIDTH-1:0] A01,
    input  logic [WIDTH-1:0] A10,
    input  logic [WIDTH-1:0] A11,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C00,
    output logic [WIDTH-1:0] C01,
    output logic [WIDTH-1:0] C10,
    output logic [WIDTH-1:0] C11,
    output logic             singular,
    output logic             saturated
);

    localparam int unsigned DW = 2 * WIDTH + 1;      // exact determinant width
    localparam int unsigned NW = WIDTH + 1;          // negated numerator must not wrap
    localparam int unsigned SH = 2 * FRAC - WIDTH;   // |n|*2^28 >= |det|*2^16 <=> |n|<<12 >= |det|
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DET  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH - 1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a00_q, a01_q, a10_q, a11_q;
    logic [DW-1:0]    det_q;
    logic [DW-2:0]    rem_q;
    logic [WIDTH-2:0] quo_q;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       idx_q;
    logic             neg_q, clamp_q, sat_q;
    logic [WIDTH-1:0] res_q [3];

    logic signed [2*WIDTH-1:0] p0, p1;
    logic [DW-1:0]    det_c, dabs, rem_init, trial;
    logic [NW-1:0]    num, nabs;
    logic             ge, load, last, sing_hit, res_sat;
    logic [WIDTH-1:0] qfin, res_val;

    assign p0    = $signed(a00_q) * $signed(a11_q);
    assign p1    = $signed(a01_q) * $signed(a10_q);
    assign det_c = {p0[2*WIDTH-1], p0} - {p1[2*WIDTH-1], p1};
    assign dabs  = det_q[DW-1] ? -det_q : det_q;

    always_comb begin
        num = '0;
        case (idx_q)
            2'd0:    num = {a11_q[WIDTH-1], a11_q};
            2'd1:    num = -{a01_q[WIDTH-1], a01_q};
            2'd2:    num = -{a10_q[WIDTH-1], a10_q};
            default: num = {a00_q[WIDTH-1], a00_q};
        endcase
    end

    assign nabs     = num[NW-1] ? -num : num;
    assign rem_init = DW'({nabs, {SH{1'b0}}});
    assign trial    = {rem_q, 1'b0};
    assign ge       = trial >= dabs;
    assign qfin     = {quo_q, ge};
    assign load     = cnt_q == '0;
    assign last     = cnt_q == CW'(WIDTH);
    assign sing_hit = load && (idx_q == 2'd0) && (det_q == '0);

    // Negative results may reach magnitude 2^(WIDTH-1); positive ones stop one short.
    always_comb begin
        res_val = '0;
        res_sat = 1'b0;
        if (clamp_q) begin
            res_val = neg_q ? MINV : MAXV;
            res_sat = 1'b1;
        end else if (neg_q) begin
            if (qfin > MINV) begin
                res_val = MINV;
                res_sat = 1'b1;
            end else begin
                res_val = -qfin;
            end
        end else if (qfin > MAXV) begin
            res_val = MAXV;
            res_sat = 1'b1;
        end else begin
            res_val = qfin;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = DET;
            DET:     state_d = DIV;
            DIV:     if (sing_hit || (last && idx_q == 2'd3)) state_d = OUT;
            default: if (out_ready) state_d = IDLE;
        endcase
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == OUT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a00_q     <= '0;
            a01_q     <= '0;
            a10_q     <= '0;
            a11_q     <= '0;
            det_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            neg_q     <= 1'b0;
            clamp_q   <= 1'b0;
            sat_q     <= 1'b0;
            res_q[0]  <= '0;
            res_q[1]  <= '0;
            res_q[2]  <= '0;
            C00       <= '0;
            C01       <= '0;
            C10       <= '0;
            C11       <= '0;
            singular  <= 1'b0;
            saturated <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a00_q <= A00;
                        a01_q <= A01;
                        a10_q <= A10;
                        a11_q <= A11;
                    end
                end
                DET: begin
                    det_q <= det_c;
                    idx_q <= '0;
                    cnt_q <= '0;
                    sat_q <= 1'b0;
                end
                DIV: begin
                    if (sing_hit) begin
                        C00       <= '0;
                        C01       <= '0;
                        C10       <= '0;
                        C11       <= '0;
                        singular  <= 1'b1;
                        saturated <= 1'b0;
                    end else if (load) begin
                        rem_q   <= rem_init[DW-2:0];
                        quo_q   <= '0;
                        neg_q   <= num[NW-1] ^ det_q[DW-1];
                        clamp_q <= rem_init >= dabs;
                        cnt_q   <= cnt_q + CW'(1);
                    end else begin
                        rem_q <= ge ? (DW - 1)'(trial - dabs) : trial[DW-2:0];
                        quo_q <= qfin[WIDTH-2:0];
                        if (last) begin
                            cnt_q <= '0;
                            idx_q <= idx_q + 2'd1;
                            sat_q <= sat_q | res_sat;
                            if (idx_q != 2'd3) begin
                                res_q[idx_q] <= res_val;
                            end else begin
                                C00       <= res_q[0];
                                C01       <= res_q[1];
                                C10       <= res_q[2];
                                C11       <= res_val;
                                singular  <= 1'b0;
                                saturated <= sat_q | res_sat;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_inv_q2_14.sv
// Directed bench for matrix_inv_q2_14: known inverses, latency, backpressure, mid-job reset.
module tb_matrix_inv_q2_14;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] A00 = '0, A01 = '0, A10 = '0, A11 = '0;
    logic        in_ready, out_valid, singular, saturated;
    logic [15:0] C00, C01, C10, C11;

    int n_checks = 0;
    int n_fails  = 0;

    matrix_inv_q2_14 #(.WIDTH(16), .FRAC(14)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A00       (A00),
        .A01       (A01),
        .A10       (A10),
        .A11       (A11),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C00       (C00),
        .C01       (C01),
        .C10       (C10),
        .C11       (C11),
        .singular  (singular),
        .saturated (saturated)
    );

    always #5 clk = ~clk;

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkint(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_job(input string name,
                           input logic signed [15:0] a00, a01, a10, a11,
                           input logic signed [15:0] e00, e01, e10, e11,
                           input logic esing, input logic esat,
                           input int elat, input int hold);
        int lat;
        chk1({name, ":in_ready_idle"}, in_ready, 1'b1);
        A00 = a00; A01 = a01; A10 = a10; A11 = a11;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chkint({name, ":latency"}, lat, elat);
        chk16({name, ":c00"}, C00, e00);
        chk16({name, ":c01"}, C01, e01);
        chk16({name, ":c10"}, C10, e10);
        chk16({name, ":c11"}, C11, e11);
        chk1({name, ":singular"}, singular, esing);
        chk1({name, ":saturated"}, saturated, esat);
        chk1({name, ":in_ready_busy"}, in_ready, 1'b0);
        // Junk matrix offered while the result is stalled must be ignored.
        for (int i = 0; i < hold; i++) begin
            A00 = 16'h1234; A01 = 16'h0777; A10 = 16'h0100; A11 = 16'h2000;
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk1({name, ":hold_valid"}, out_valid, 1'b1);
            chk1({name, ":hold_in_ready"}, in_ready, 1'b0);
            chk16({name, ":hold_c01"}, C01, e01);
            chk1({name, ":hold_sat"}, saturated, esat);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk1({name, ":drained"}, out_valid, 1'b0);
        chk1({name, ":in_ready_back"}, in_ready, 1'b1);
    endtask

    initial begin
        int seen;
        repeat (2) @(posedge clk);
        #1;
        chk1("reset:in_ready", in_ready, 1'b1);
        chk1("reset:out_valid", out_valid, 1'b0);
        chk16("reset:c00", C00, 16'd0);
        chk16("reset:c11", C11, 16'd0);
        chk1("reset:singular", singular, 1'b0);
        chk1("reset:saturated", saturated, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_job("identity", 16'sd16384, 16'sd0, 16'sd0, 16'sd16384,
                16'sd16384, 16'sd0, 16'sd0, 16'sd16384, 1'b0, 1'b0, 69, 0);
        run_job("shear", 16'sd16384, 16'sd8192, 16'sd0, 16'sd16384,
                16'sd16384, -16'sd8192, 16'sd0, 16'sd16384, 1'b0, 1'b0, 69, 0);
        run_job("rotation", 16'sd0, 16'sd16384, -16'sd16384, 16'sd0,
                16'sd0, -16'sd16384, 16'sd16384, 16'sd0, 1'b0, 1'b0, 69, 0);
        run_job("saturate", 16'sd8192, 16'sd0, 16'sd0, 16'sd8192,
                16'sd32767, 16'sd0, 16'sd0, 16'sd32767, 1'b0, 1'b1, 69, 0);
        run_job("singular", 16'sd16384, 16'sd16384, 16'sd16384, 16'sd16384,
                16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b1, 1'b0, 2, 0);
        run_job("backpressure", 16'sd16384, 16'sd8192, 16'sd0, 16'sd16384,
                16'sd16384, -16'sd8192, 16'sd0, 16'sd16384, 1'b0, 1'b0, 69, 10);

        // Abandon a job partway through division.
        A00 = 16'sd16384; A01 = 16'sd0; A10 = 16'sd0; A11 = 16'sd16384;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (31) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk16("midreset:c00", C00, 16'd0);
        chk16("midreset:c11", C11, 16'd0);
        chk1("midreset:out_valid", out_valid, 1'b0);
        chk1("midreset:in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chkint("midreset:no_out_valid", seen, 0);

        run_job("post_reset", 16'sd16384, 16'sd0, 16'sd0, 16'sd16384,
                16'sd16384, 16'sd0, 16'sd0, 16'sd16384, 1'b0, 1'b0, 69, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
